// File: rtl/mem_responder.sv
// Line-burst memory responder: accepts a line request, waits a fixed latency,
// then streams LINE_WORDS read beats out of, or write beats into, a local store.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 26,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_type,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy
);

  localparam int unsigned BW = $clog2(LINE_WORDS);
  localparam int unsigned IW = $clog2(DEPTH_WORDS);
  localparam int unsigned WW = $clog2(LATENCY + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [IW-1:0] LINE_MASK = IW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RD_BURST, WR_BURST} state_t;

  state_t          state;
  logic [IW-1:0]   base;
  logic            is_read;
  logic [BW-1:0]   beat;
  logic [WW-1:0]   wait_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [BW-1:0]   beat_next_c;
  logic [IW-1:0]   idx_c;
  logic [IW-1:0]   idx_next_c;
  logic            wr_fire_c;
  logic            rd_fire_c;
  logic            unused_addr_bits_c;

  // Only the low IW address bits select a word; higher bits alias.
  assign unused_addr_bits_c = ^req_addr[ADDR_WIDTH-1:IW];

  assign beat_next_c = beat + BW'(1);
  assign idx_c       = base + IW'(beat);
  assign idx_next_c  = base + IW'(beat_next_c);
  assign wr_fire_c   = (state == WR_BURST) && wr_valid && wr_ready;
  assign rd_fire_c   = (state == RD_BURST) && rd_valid && rd_ready;

  // Backing store is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      mem[idx_c] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      is_read   <= 1'b0;
      beat      <= '0;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            base      <= req_addr[IW-1:0] & ~LINE_MASK;
            is_read   <= req_type;
            beat      <= '0;
            wait_cnt  <= WW'(LATENCY - 1);
            state     <= WAIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WW'(1);
          end else if (is_read) begin
            state    <= RD_BURST;
            rd_valid <= 1'b1;
            rd_data  <= mem[idx_c];
            rd_last  <= (beat == LAST_BEAT);
          end else begin
            state    <= WR_BURST;
            wr_ready <= 1'b1;
          end
        end
        RD_BURST: begin
          // Data and last only move on a completed handshake.
          if (rd_fire_c) begin
            if (beat == LAST_BEAT) begin
              state     <= IDLE;
              beat      <= '0;
              rd_valid  <= 1'b0;
              rd_last   <= 1'b0;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              beat    <= beat_next_c;
              rd_data <= mem[idx_next_c];
              rd_last <= (beat_next_c == LAST_BEAT);
            end
          end
        end
        WR_BURST: begin
          if (wr_fire_c) begin
            if (beat == LAST_BEAT) begin
              state     <= IDLE;
              beat      <= '0;
              wr_ready  <= 1'b0;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              beat <= beat_next_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, write/read bursts, backpressure,
// alignment/aliasing, reset mid-burst and ignored requests.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [25:0] req_addr;
  logic        req_type;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_type  (req_type),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_line(input logic [25:0] addr, input logic [31:0] first, input int nbeats);
    int n;
    check("wr_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_type  = 1'b0;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!wr_ready && n < 20) begin
      check("wr_wait_ready_low", wr_ready, 0);
      tick();
      n++;
    end
    check("wr_latency", n, 4);
    for (int i = 0; i < nbeats; i++) begin
      wr_valid = 1'b1;
      wr_data  = first + 32'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_line(input logic [25:0] addr, input logic [31:0] e [4],
                           input int stall_beat, input int stall_n, input bit hold_req);
    int n;
    req_valid = 1'b1;
    req_type  = 1'b1;
    req_addr  = addr;
    rd_ready  = 1'b0;
    tick();
    if (!hold_req) req_valid = 1'b0;
    check("rd_wait_busy", busy, 1);
    check("rd_wait_req_ready", req_ready, 0);
    n = 1;
    while (!rd_valid && n < 20) begin
      tick();
      n++;
    end
    check("rd_first_valid_cycle", n, 5);
    for (int b = 0; b < 4; b++) begin
      if (b == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          check("stall_valid", rd_valid, 1);
          check("stall_data", rd_data, e[b]);
          check("stall_last", rd_last, (b == 3));
          tick();
        end
      end
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, e[b]);
      check("rd_last", rd_last, (b == 3));
      rd_ready = 1'b1;
      if (b == 3) req_valid = 1'b0;
      tick();
      rd_ready = 1'b0;
    end
    check("rd_done_busy", busy, 0);
    check("rd_done_valid", rd_valid, 0);
    check("rd_done_req_ready", req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ea [4];
    logic [31:0] ec [4];
    ea = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    ec = '{32'hC0, 32'hC1, 32'hB2, 32'hB3};

    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_type  = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;

    // Asynchronous reset with no clock edge yet
    #2 rst = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_data", rd_data, 0);
    tick();
    rst = 1'b0;
    tick();

    write_line(26'h40, 32'hA0, 4);
    check("wr_done_wr_ready", wr_ready, 0);
    check("wr_done_busy", busy, 0);
    check("wr_done_req_ready", req_ready, 1);

    read_line(26'h40, ea, -1, 0, 1'b0);
    read_line(26'h40, ea, 1, 3, 1'b0);
    read_line(26'h43, ea, -1, 0, 1'b0);
    read_line(26'h440, ea, -1, 0, 1'b0);

    // Partial write abandoned by reset mid-burst
    write_line(26'h80, 32'hB0, 4);
    write_line(26'h80, 32'hC0, 2);
    check("pre_rst_wr_ready", wr_ready, 1);
    rst = 1'b1;
    #1;
    check("midrst_wr_ready", wr_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_rd_data", rd_data, 0);
    tick();
    rst = 1'b0;
    tick();
    read_line(26'h80, ec, -1, 0, 1'b0);

    // req_valid held through WAIT and burst must not start a second transaction
    read_line(26'h40, ea, 2, 1, 1'b1);
    tick();
    check("ignored_busy_1", busy, 0);
    tick();
    check("ignored_busy_2", busy, 0);
    check("ignored_rd_valid", rd_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 26, word-address width of requests.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of one data beat.
REQ-003 SHALL have parameter LINE_WORDS, default 4, beats per line burst (power of two, >=2).
REQ-004 SHALL have parameter LATENCY, default 4, wait cycles between request and first beat (>=1).
REQ-005 SHALL have parameter DEPTH_WORDS, default 1024, backing store size in words (power of two).
REQ-006 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-007 Port: rst  in  1  asynchronous, active-high reset.
REQ-008 Port: req_valid  in  1  line request present.
REQ-009 Port: req_ready  out  1  responder can accept a request.
REQ-010 Port: req_addr  in  ADDR_WIDTH  word address of line.
REQ-011 Port: req_type  in  1  mips_core_pkg::MemAccessType (WRITE=0, READ=1).
REQ-012 Port: wr_valid  in  1  / wr_ready  out  1  / wr_data  in  DATA_WIDTH  write-beat channel.
REQ-013 Port: rd_valid  out  1  / rd_ready  in  1  / rd_data  out  DATA_WIDTH  / rd_last  out  1  read-beat channel.
REQ-014 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RD_BURST, WR_BURST.
REQ-016 SHALL drive req_ready=1 only in IDLE; req_valid outside IDLE is ignored.
REQ-017 On req_valid&req_ready at edge N, SHALL latch base=req_addr with low log2(LINE_WORDS) bits cleared, latch req_type, clear beat counter, load wait counter, and enter WAIT.
REQ-018 SHALL remain in WAIT for exactly LATENCY cycles (N+1..N+LATENCY), then enter RD_BURST (READ) or WR_BURST (WRITE) in cycle N+LATENCY+1.
REQ-019 In RD_BURST, SHALL assert rd_valid with rd_data=mem[(base+beat) mod DEPTH_WORDS]; rd_last=1 only when beat==LINE_WORDS-1.
REQ-020 In RD_BURST, beat SHALL advance only on rd_valid&rd_ready; rd_data and rd_last SHALL hold stable while rd_ready is low.
REQ-021 In WR_BURST, SHALL assert wr_ready; on wr_valid&wr_ready SHALL write wr_data to mem[(base+beat) mod DEPTH_WORDS] and advance beat.
REQ-022 After the handshake of beat LINE_WORDS-1, SHALL return to IDLE in the next cycle; back-to-back requests are accepted from that IDLE cycle.
REQ-023 Beat counter SHALL be log2(LINE_WORDS) bits; addresses at or beyond DEPTH_WORDS SHALL alias modulo DEPTH_WORDS.
REQ-024 A write completed before a read request is accepted SHALL be visible to that read.
REQ-025 rd_valid, rd_last, wr_ready SHALL be 0 in every state other than their own burst state.

Reset
REQ-026 On rst assertion, SHALL asynchronously enter IDLE with beat and wait counters zero; rd_valid=0, rd_last=0, wr_ready=0, busy=0, req_ready=1, rd_data=0.
REQ-027 Reset mid-burst or mid-WAIT SHALL abandon the transaction with no further writes; backing store contents SHALL NOT be cleared by reset.

Verification
REQ-028 Reset: assert rst mid-cycle with no clock -> outputs immediately match REQ-026.
REQ-029 Write then read: WRITE addr 0x40, beats 0xA0,0xA1,0xA2,0xA3; READ addr 0x40 handshake at edge N -> rd_valid first high in cycle N+5, data 0xA0..0xA3, rd_last only on 0xA3, busy low the cycle after.
REQ-030 Backpressure: during READ hold rd_ready=0 for 3 cycles at beat 1 -> rd_data stays 0xA1, rd_last=0, no beat skipped or repeated.
REQ-031 Alignment/alias: READ addr 0x43 and addr DEPTH_WORDS+0x40 -> both return 0xA0..0xA3.
REQ-032 Reset mid-burst: WRITE 0x80 with 0xB0..0xB3, then WRITE 0x80 with 0xC0,0xC1 and rst asserted before beat 2 -> IDLE, wr_ready=0; subsequent READ 0x80 returns 0xC0,0xC1,0xB2,0xB3.
REQ-033 Ignored request: req_valid held high during WAIT of prior READ -> req_ready=0, only one transaction served until IDLE.
